// File: rtl/rv32_dbg_pkg.sv
// Shared encodings for the rv32 run-control block: run states, host commands,
// halt causes and debug output selectors.
package rv32_dbg_pkg;

  typedef enum logic [1:0] {
    StHalted = 2'd0,
    StRun    = 2'd1,
    StStep   = 2'd2
  } run_state_e;

  typedef enum logic [2:0] {
    CmdNop      = 3'd0,
    CmdHalt     = 3'd1,
    CmdResume   = 3'd2,
    CmdStep     = 3'd3,
    CmdSetBp    = 3'd4,
    CmdClrBp    = 3'd5,
    CmdClrCnt   = 3'd6,
    CmdClrTrace = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    CauseReset = 2'd0,
    CauseHost  = 2'd1,
    CauseBp    = 2'd2,
    CauseStep  = 2'd3
  } halt_cause_e;

  typedef enum logic [1:0] {
    DbgPc      = 2'd0,
    DbgCycle   = 2'd1,
    DbgInstret = 2'd2,
    DbgStatus  = 2'd3
  } dbg_sel_e;

endpackage

// File: rtl/rv32_run_ctrl_if.sv
// Host-side command channel and trace read port of the run-control block.
interface rv32_run_ctrl_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_BP      = 4,
  parameter int unsigned TRACE_DEPTH = 16
);
  localparam int unsigned IdxW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
  localparam int unsigned CntW = $clog2(TRACE_DEPTH) + 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [IdxW-1:0] cmd_idx;
  logic [XLEN-1:0] cmd_data;
  logic            trace_rd;
  logic [XLEN-1:0] trace_data;
  logic            trace_empty;
  logic [CntW-1:0] trace_count;
  logic            trace_ovf;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_data, trace_rd,
    input  cmd_ready, trace_data, trace_empty, trace_count, trace_ovf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_data, trace_rd,
    output cmd_ready, trace_data, trace_empty, trace_count, trace_ovf
  );
endinterface

// File: rtl/rv32_trace_fifo.sv
// Show-ahead FIFO of retired PCs; a push into a full FIFO overwrites the oldest
// entry and sets a sticky overflow flag.
module rv32_trace_fifo #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [XLEN-1:0]                din,
  output logic [XLEN-1:0]                data,
  output logic                           empty,
  output logic [$clog2(TRACE_DEPTH):0]   count,
  output logic                           ovf
);
  localparam int unsigned AW = $clog2(TRACE_DEPTH);

  logic [XLEN-1:0] r_mem [TRACE_DEPTH];
  logic [AW-1:0]   r_head, r_tail;
  logic [AW:0]     r_count;
  logic            r_ovf;
  logic            w_full, w_pop;

  assign w_full = (r_count == (AW+1)'(TRACE_DEPTH));
  assign w_pop  = pop && (r_count != '0);

  always_ff @(posedge clock) begin
    if (push && !clear) r_mem[r_tail] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (push) r_tail <= r_tail + 1'b1;
      // Full push without pop drops the oldest entry by moving head past it.
      if (w_pop || (push && w_full)) r_head <= r_head + 1'b1;
      if (push && !w_pop && w_full) r_ovf <= 1'b1;
      if (push && !w_pop && !w_full) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign data  = r_mem[r_head];
  assign empty = (r_count == '0);
  assign count = r_count;
  assign ovf   = r_ovf;
endmodule

// File: rtl/rv32_run_ctrl.sv
// Run-control for the rv32is core: gates core_en for run/halt/step/breakpoints,
// counts cycles and retirements, traces retired PCs and muxes debugdata.
module rv32_run_ctrl
  import rv32_dbg_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_BP      = 4,
  parameter int unsigned TRACE_DEPTH = 16,
  parameter int unsigned CNT_W       = 32,
  parameter bit          START_RUN   = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            retire,
  output logic            core_en,
  output logic [1:0]      state,
  output logic [1:0]      halt_cause,
  input  logic [1:0]      dbg_sel,
  output logic [XLEN-1:0] debugdata,
  rv32_run_ctrl_if.slave  bus
);
  run_state_e      r_state;
  halt_cause_e     r_cause;
  logic            r_skip_bp;
  logic [NUM_BP-1:0] r_bp_en;
  logic [XLEN-1:0] r_bp_addr [NUM_BP];
  logic [CNT_W-1:0] r_cycle, r_instret;

  logic    w_bp_hit, w_bp_eff, w_cmd_acc, w_retire, w_idx_ok, w_trace_ovf;
  cmd_op_e w_op;

  always_comb begin
    w_bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (r_bp_en[i] && (r_bp_addr[i] == pc_in)) w_bp_hit = 1'b1;
    end
  end

  assign w_bp_eff      = w_bp_hit && !r_skip_bp;
  assign core_en       = ((r_state == StRun) && !w_bp_eff) || (r_state == StStep);
  assign bus.cmd_ready = (r_state != StStep);
  assign w_cmd_acc     = bus.cmd_valid && bus.cmd_ready;
  assign w_op          = cmd_op_e'(bus.cmd_op);
  assign w_retire      = retire && core_en;
  assign w_idx_ok      = (32'(bus.cmd_idx) < NUM_BP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= START_RUN ? StRun : StHalted;
      r_cause   <= CauseReset;
      r_skip_bp <= 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          // A live breakpoint outranks a same-cycle host halt.
          if (w_bp_eff) begin
            r_state <= StHalted;
            r_cause <= CauseBp;
          end else if (w_cmd_acc && (w_op == CmdHalt)) begin
            r_state <= StHalted;
            r_cause <= CauseHost;
          end
          if (w_retire) r_skip_bp <= 1'b0;
        end
        StHalted: begin
          if (w_cmd_acc && (w_op == CmdResume)) begin
            r_state   <= StRun;
            r_skip_bp <= 1'b1;
          end else if (w_cmd_acc && (w_op == CmdStep)) begin
            r_state <= StStep;
          end
        end
        StStep: begin
          if (retire) begin
            r_state <= StHalted;
            r_cause <= CauseStep;
          end
        end
        default: r_state <= StHalted;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bp_en <= '0;
      for (int i = 0; i < NUM_BP; i++) r_bp_addr[i] <= '0;
    end else if (w_cmd_acc && w_idx_ok) begin
      if (w_op == CmdSetBp) begin
        r_bp_addr[bus.cmd_idx] <= bus.cmd_data;
        r_bp_en[bus.cmd_idx]   <= 1'b1;
      end else if (w_op == CmdClrBp) begin
        r_bp_en[bus.cmd_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else if (w_cmd_acc && (w_op == CmdClrCnt)) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (core_en)  r_cycle   <= r_cycle + 1'b1;
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end

  rv32_trace_fifo #(
    .XLEN        (XLEN),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_retire),
    .pop   (bus.trace_rd),
    .clear (w_cmd_acc && (w_op == CmdClrTrace)),
    .din   (pc_in),
    .data  (bus.trace_data),
    .empty (bus.trace_empty),
    .count (bus.trace_count),
    .ovf   (w_trace_ovf)
  );

  assign bus.trace_ovf = w_trace_ovf;
  assign state         = r_state;
  assign halt_cause    = r_cause;

  always_comb begin
    debugdata = '0;
    unique case (dbg_sel_e'(dbg_sel))
      DbgPc:      debugdata = pc_in;
      DbgCycle:   debugdata = XLEN'(r_cycle);
      DbgInstret: debugdata = XLEN'(r_instret);
      DbgStatus:  debugdata[4:0] = {w_trace_ovf, r_cause, r_state};
      default:    debugdata = '0;
    endcase
  end
endmodule
